// File: rtl/clk_period_meter.sv
// Measures the period of an asynchronous slow clock/strobe in clockin cycles,
// with lock detection on repeated identical periods and stall detection on missing edges.
module clk_period_meter #(
  parameter int unsigned CNT_W  = 16,
  parameter int unsigned LOCK_N = 4
) (
  input  logic             clockin,
  input  logic             reset,
  input  logic             sig_in,
  output logic             edge_pulse,
  output logic [CNT_W-1:0] period,
  output logic             period_valid,
  output logic             locked,
  output logic             stalled
);

  localparam int unsigned       MATCH_W   = (LOCK_N > 2) ? $clog2(LOCK_N) : 1;
  localparam logic [CNT_W-1:0]  CNT_MAX   = '1;
  localparam logic [MATCH_W-1:0] MATCH_TOP = MATCH_W'(LOCK_N - 1);

  typedef enum logic [1:0] {
    IDLE,
    MEASURE,
    TRACK
  } state_t;

  state_t             state_q, state_d;
  logic               s1_q, s1_d;
  logic               s2_q, s2_d;
  logic               hist_q, hist_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [MATCH_W-1:0] match_q, match_d;
  logic               edge_pulse_q, edge_pulse_d;
  logic [CNT_W-1:0]   period_q, period_d;
  logic               period_valid_q, period_valid_d;
  logic               locked_q, locked_d;
  logic               stalled_q, stalled_d;

  logic               edge_det;
  logic               cnt_at_max;
  logic [CNT_W-1:0]   period_next;

  always_comb begin
    s1_d           = sig_in;
    s2_d           = s1_q;
    hist_d         = s2_q;
    edge_det       = s2_q & ~hist_q;
    cnt_at_max     = (cnt_q == CNT_MAX);
    // cnt holds the cycles since the last edge minus one, so +1 gives edge-to-edge distance
    period_next    = cnt_at_max ? CNT_MAX : cnt_q + CNT_W'(1);

    state_d        = state_q;
    match_d        = match_q;
    period_d       = period_q;
    locked_d       = locked_q;
    stalled_d      = stalled_q;
    edge_pulse_d   = edge_det;
    period_valid_d = 1'b0;

    if (edge_det) begin
      cnt_d = '0;
    end else if (cnt_at_max) begin
      cnt_d = cnt_q;
    end else begin
      cnt_d = cnt_q + CNT_W'(1);
    end

    case (state_q)
      IDLE: begin
        if (edge_det) begin
          state_d   = MEASURE;
          stalled_d = 1'b0;
        end
      end
      MEASURE, TRACK: begin
        // an edge coinciding with a saturated counter reports MAX instead of stalling
        if (edge_det) begin
          period_d       = period_next;
          period_valid_d = 1'b1;
          state_d        = TRACK;
          if (state_q == MEASURE) begin
            match_d  = '0;
            locked_d = 1'b0;
          end else if (period_next == period_q) begin
            match_d = (match_q == MATCH_TOP) ? MATCH_TOP : match_q + MATCH_W'(1);
            if (match_d == MATCH_TOP) begin
              locked_d = 1'b1;
            end
          end else begin
            match_d  = '0;
            locked_d = 1'b0;
          end
        end else if (cnt_at_max) begin
          stalled_d = 1'b1;
          locked_d  = 1'b0;
          match_d   = '0;
          state_d   = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clockin) begin
    if (reset) begin
      state_q        <= IDLE;
      s1_q           <= 1'b0;
      s2_q           <= 1'b0;
      hist_q         <= 1'b0;
      cnt_q          <= '0;
      match_q        <= '0;
      edge_pulse_q   <= 1'b0;
      period_q       <= '0;
      period_valid_q <= 1'b0;
      locked_q       <= 1'b0;
      stalled_q      <= 1'b0;
    end else begin
      state_q        <= state_d;
      s1_q           <= s1_d;
      s2_q           <= s2_d;
      hist_q         <= hist_d;
      cnt_q          <= cnt_d;
      match_q        <= match_d;
      edge_pulse_q   <= edge_pulse_d;
      period_q       <= period_d;
      period_valid_q <= period_valid_d;
      locked_q       <= locked_d;
      stalled_q      <= stalled_d;
    end
  end

  assign edge_pulse   = edge_pulse_q;
  assign period       = period_q;
  assign period_valid = period_valid_q;
  assign locked       = locked_q;
  assign stalled      = stalled_q;

endmodule

// File: tb/tb_clk_period_meter.sv
// Scoreboard bench for clk_period_meter: a rising-edge timeline model predicts
// edge/period/lock/stall events, and a monitor compares them as the DUT emits them.
module tb_clk_period_meter;

  localparam int unsigned CNT_W  = 8;
  localparam int unsigned LOCK_N = 4;
  localparam int          MAXV   = 255;

  logic             clockin = 1'b0;
  logic             reset   = 1'b1;
  logic             sig_in  = 1'b0;
  logic             edge_pulse;
  logic [CNT_W-1:0] period;
  logic             period_valid;
  logic             locked;
  logic             stalled;

  clk_period_meter #(.CNT_W(CNT_W), .LOCK_N(LOCK_N)) dut (
    .clockin      (clockin),
    .reset        (reset),
    .sig_in       (sig_in),
    .edge_pulse   (edge_pulse),
    .period       (period),
    .period_valid (period_valid),
    .locked       (locked),
    .stalled      (stalled)
  );

  always #5 clockin = ~clockin;

  typedef struct {
    bit valid;
    int per;
    bit lk;
  } edge_ev_t;

  edge_ev_t edge_q[$];
  int       stall_q[$];
  int       tests = 0;
  int       fails = 0;

  // reference model state: a timeline of sampled rising edges
  bit prev_v   = 1'b0;
  bit has_ref  = 1'b0;
  int t        = 0;
  int last_t   = 0;
  int last_per = 0;
  int hist[$];

  task automatic check(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic bit lock_now();
    int n;
    n = hist.size();
    if (n < int'(LOCK_N)) return 1'b0;
    for (int i = 1; i < int'(LOCK_N); i++) begin
      if (hist[n-1-i] != hist[n-1]) return 1'b0;
    end
    return 1'b1;
  endfunction

  task automatic model_sample(input bit v);
    bit rising;
    int gap;
    int p;
    edge_ev_t e;
    rising = v && !prev_v;
    prev_v = v;
    if (rising) begin
      if (!has_ref) begin
        has_ref = 1'b1;
        hist.delete();
        e.valid = 1'b0;
        e.per   = last_per;
        e.lk    = 1'b0;
      end else begin
        gap = t - last_t;
        p   = (gap > MAXV) ? MAXV : gap;
        hist.push_back(p);
        last_per = p;
        e.valid  = 1'b1;
        e.per    = p;
        e.lk     = lock_now();
      end
      edge_q.push_back(e);
      last_t = t;
    end else if (has_ref && (t - last_t) == MAXV + 1) begin
      stall_q.push_back(last_per);
      has_ref = 1'b0;
    end
  endtask

  task automatic drive(input bit v, input int n);
    repeat (n) begin
      @(negedge clockin);
      sig_in = v;
      t++;
      model_sample(v);
    end
  endtask

  task automatic wave(input int hi, input int lo, input int reps);
    repeat (reps) begin
      drive(1'b1, hi);
      drive(1'b0, lo);
    end
  endtask

  task automatic do_reset(input int n);
    @(negedge clockin);
    reset = 1'b1;
    edge_q.delete();
    stall_q.delete();
    repeat (n) @(negedge clockin);
    check("rst_edge_pulse", int'(edge_pulse), 0);
    check("rst_period", int'(period), 0);
    check("rst_period_valid", int'(period_valid), 0);
    check("rst_locked", int'(locked), 0);
    check("rst_stalled", int'(stalled), 0);
    reset    = 1'b0;
    prev_v   = 1'b0;
    has_ref  = 1'b0;
    last_per = 0;
    hist.delete();
    t++;
    model_sample(sig_in);
  endtask

  bit prev_st = 1'b0;

  always @(posedge clockin) begin
    edge_ev_t e;
    int sp;
    #1;
    if (reset) begin
      prev_st = 1'b0;
    end else begin
      if (period_valid && !edge_pulse) check("valid_without_edge", 1, 0);
      if (edge_pulse) begin
        if (edge_q.size() == 0) begin
          check("edge_unexpected", 0, 1);
        end else begin
          e = edge_q.pop_front();
          check("edge_valid", int'(period_valid), int'(e.valid));
          check("edge_period", int'(period), e.per);
          check("edge_locked", int'(locked), int'(e.lk));
          check("edge_stalled", int'(stalled), 0);
        end
      end
      if (stalled && !prev_st) begin
        if (stall_q.size() == 0) begin
          check("stall_unexpected", 0, 1);
        end else begin
          sp = stall_q.pop_front();
          check("stall_period_hold", int'(period), sp);
          check("stall_locked", int'(locked), 0);
        end
      end
      prev_st = stalled;
    end
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int p;
    int hi;
    do_reset(3);

    wave(4, 4, 8);                // period 8, lock on 4th report
    wave(8, 8, 6);                // switch to 16, unlock then relock
    drive(1'b0, 300);             // stall while locked
    wave(4, 4, 3);
    wave(128, 128, 5);            // period MAX+1 saturates, no stall
    wave(150, 150, 2);            // period beyond MAX stalls
    wave(4, 4, 6);

    drive(1'b1, 8);               // reset mid-track with sig_in high
    do_reset(2);
    drive(1'b1, 2);
    drive(1'b0, 4);
    wave(4, 4, 3);

    wave(1, 1, 10);               // fastest measurable input

    for (int k = 0; k < 30; k++) begin
      p  = $urandom_range(40, 2);
      hi = $urandom_range(p - 1, 1);
      wave(hi, p - hi, $urandom_range(6, 1));
      if ($urandom_range(7, 0) == 0) drive(1'b0, $urandom_range(262, 250));
    end

    drive(1'b0, 300);
    repeat (10) @(negedge clockin);
    check("edge_queue_drained", edge_q.size(), 0);
    check("stall_queue_drained", stall_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
